// File: rtl/pipelined_control_unit_pkg.sv
// rtl/pipelined_control_unit_pkg.sv - shared encodings, opcode constants and control bundle
package pipelined_control_unit_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRA  = 4'd1,
    ALU_SRL  = 4'd2,
    ALU_ADD  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_AND  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_XOR  = 4'd9,
    ALU_NOR  = 4'd10,
    ALU_SLT  = 4'd11,
    ALU_SLTU = 4'd12
  } alumode_e;

  typedef enum logic [1:0] {SRC_RT, SRC_IMM, SRC_SHAMT, SRC_RSV} alusrc_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} regdst_e;
  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE, BR_GEZ} branch_e;
  typedef enum logic [1:0] {JMP_NONE, JMP_TARGET, JMP_REG} jump_e;
  typedef enum logic {ST_RUN, ST_HALT} state_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  localparam logic [4:0] RT_BGEZ   = 5'd1;

  typedef struct packed {
    alumode_e alumode;
    alusrc_e  alusrc;
    logic     signext;
    logic     regwrite;
    regdst_e  regdst;
    logic     memread;
    logic     memwrite;
    logic     memhalf;
    branch_e  branch;
    jump_e    jump;
    logic     syscall;
    logic     illegal;
  } ctrl_t;

endpackage

// File: rtl/pcu_decode.sv
// rtl/pcu_decode.sv - combinational instruction word to control bundle decoder
module pcu_decode
  import pipelined_control_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_fields;
  ctrl_t      c;

  assign op            = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign rt            = instr_i[20:16];
  assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};

  always_comb begin
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        case (funct)
          F_ADD, F_ADDU: c.alumode = ALU_ADD;
          F_SUB:         c.alumode = ALU_SUB;
          F_AND:         c.alumode = ALU_AND;
          F_OR:          c.alumode = ALU_OR;
          F_XOR:         c.alumode = ALU_XOR;
          F_NOR:         c.alumode = ALU_NOR;
          F_SLT:         c.alumode = ALU_SLT;
          F_SLTU:        c.alumode = ALU_SLTU;
          F_SLL:   begin c.alumode = ALU_SLL; c.alusrc = SRC_SHAMT; end
          F_SRL:   begin c.alumode = ALU_SRL; c.alusrc = SRC_SHAMT; end
          F_SRA:   begin c.alumode = ALU_SRA; c.alusrc = SRC_SHAMT; end
          F_SRLV:  begin c.alumode = ALU_SRL; c.alusrc = SRC_RSV;   end
          F_JR:    begin c.regwrite = 1'b0; c.jump = JMP_REG; end
          F_SYSCALL: begin c.regwrite = 1'b0; c.syscall = 1'b1; end
          default: begin c.regwrite = 1'b0; c.illegal = 1'b1; end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        c.alumode = ALU_ADD; c.alusrc = SRC_IMM; c.signext = 1'b1;
        c.regwrite = 1'b1; c.regdst = DST_RT;
      end
      OP_ANDI: begin
        c.alumode = ALU_AND; c.alusrc = SRC_IMM; c.regwrite = 1'b1; c.regdst = DST_RT;
      end
      OP_ORI: begin
        c.alumode = ALU_OR; c.alusrc = SRC_IMM; c.regwrite = 1'b1; c.regdst = DST_RT;
      end
      OP_SLTI: begin
        c.alumode = ALU_SLT; c.alusrc = SRC_IMM; c.signext = 1'b1;
        c.regwrite = 1'b1; c.regdst = DST_RT;
      end
      OP_LW, OP_LHU: begin
        c.alumode = ALU_ADD; c.alusrc = SRC_IMM; c.signext = 1'b1;
        c.memread = 1'b1; c.regwrite = 1'b1; c.regdst = DST_RT;
        c.memhalf = (op == OP_LHU);
      end
      OP_SW: begin
        c.alumode = ALU_ADD; c.alusrc = SRC_IMM; c.signext = 1'b1; c.memwrite = 1'b1;
      end
      OP_BEQ: begin c.alumode = ALU_SUB; c.branch = BR_EQ; end
      OP_BNE: begin c.alumode = ALU_SUB; c.branch = BR_NE; end
      OP_REGIMM: begin
        // only bgez is implemented in the regimm space
        if (rt == RT_BGEZ) begin
          c.alumode = ALU_SLT; c.branch = BR_GEZ;
        end else begin
          c.illegal = 1'b1;
        end
      end
      OP_J:   c.jump = JMP_TARGET;
      OP_JAL: begin c.jump = JMP_TARGET; c.regwrite = 1'b1; c.regdst = DST_RA; end
      default: c.illegal = 1'b1;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - registered decode stage with halt FSM and retired counter
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_SYSCALL = 1'b1,
  parameter bit ILLEGAL_TRAP    = 1'b1
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             out_ready,
  output logic             out_valid,
  input  logic             in_ready,
  input  logic             in_flush,
  input  logic             in_resume,
  output logic [3:0]       out_alumode,
  output logic [1:0]       out_alusrc,
  output logic             out_signext,
  output logic             out_regwrite,
  output logic [1:0]       out_regdst,
  output logic             out_memread,
  output logic             out_memwrite,
  output logic             out_memhalf,
  output logic [1:0]       out_branch,
  output logic [1:0]       out_jump,
  output logic             out_syscall,
  output logic             out_illegal,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_instr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t            dec_ctrl;
  ctrl_t            ctrl_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  state_e           state_q, state_d;
  logic             pend, accept, xfer;

  pcu_decode u_decode (
    .instr_i (in_instr),
    .ctrl_o  (dec_ctrl)
  );

  assign pend = valid_q & ((ctrl_q.syscall & HALT_ON_SYSCALL) | (ctrl_q.illegal & ILLEGAL_TRAP));
  assign out_ready = ~in_rst & (state_q == ST_RUN) & ~pend & (~valid_q | in_ready);
  assign accept = in_valid & out_ready;
  // a flushed stage is killed, so it neither counts nor halts
  assign xfer = valid_q & in_ready & ~in_flush;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (in_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cnt_q <= '0;
    end else if (xfer && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (xfer && pend && !in_resume) state_d = ST_HALT;
      ST_HALT: if (in_resume) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign out_valid     = valid_q;
  assign out_alumode   = ctrl_q.alumode;
  assign out_alusrc    = ctrl_q.alusrc;
  assign out_signext   = ctrl_q.signext;
  assign out_regwrite  = ctrl_q.regwrite;
  assign out_regdst    = ctrl_q.regdst;
  assign out_memread   = ctrl_q.memread;
  assign out_memwrite  = ctrl_q.memwrite;
  assign out_memhalf   = ctrl_q.memhalf;
  assign out_branch    = ctrl_q.branch;
  assign out_jump      = ctrl_q.jump;
  assign out_syscall   = ctrl_q.syscall;
  assign out_illegal   = ctrl_q.illegal;
  assign out_halted    = (state_q == ST_HALT);
  assign out_instr_cnt = cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - scoreboard bench for the registered decode stage
module tb_pipelined_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_valid, a_rdy, a_ovld, a_dsready, a_flush, a_resume;
  logic [31:0] a_instr;
  logic [3:0]  a_alumode;
  logic [1:0]  a_alusrc, a_regdst, a_branch, a_jump;
  logic        a_signext, a_regwrite, a_memread, a_memwrite, a_memhalf;
  logic        a_syscall, a_illegal, a_halted;
  logic [31:0] a_cnt;
  logic [18:0] a_obs;

  logic        b_valid, b_rdy, b_ovld, b_dsready, b_flush, b_resume;
  logic [31:0] b_instr;
  logic [3:0]  b_alumode;
  logic [1:0]  b_alusrc, b_regdst, b_branch, b_jump;
  logic        b_signext, b_regwrite, b_memread, b_memwrite, b_memhalf;
  logic        b_syscall, b_illegal, b_halted;
  logic [1:0]  b_cnt;

  pipelined_control_unit dut_a (
    .in_clk(clk), .in_rst(rst), .in_valid(a_valid), .in_instr(a_instr),
    .out_ready(a_rdy), .out_valid(a_ovld), .in_ready(a_dsready), .in_flush(a_flush),
    .in_resume(a_resume), .out_alumode(a_alumode), .out_alusrc(a_alusrc),
    .out_signext(a_signext), .out_regwrite(a_regwrite), .out_regdst(a_regdst),
    .out_memread(a_memread), .out_memwrite(a_memwrite), .out_memhalf(a_memhalf),
    .out_branch(a_branch), .out_jump(a_jump), .out_syscall(a_syscall),
    .out_illegal(a_illegal), .out_halted(a_halted), .out_instr_cnt(a_cnt)
  );

  pipelined_control_unit #(.CNT_W(2), .HALT_ON_SYSCALL(1'b1), .ILLEGAL_TRAP(1'b0)) dut_b (
    .in_clk(clk), .in_rst(rst), .in_valid(b_valid), .in_instr(b_instr),
    .out_ready(b_rdy), .out_valid(b_ovld), .in_ready(b_dsready), .in_flush(b_flush),
    .in_resume(b_resume), .out_alumode(b_alumode), .out_alusrc(b_alusrc),
    .out_signext(b_signext), .out_regwrite(b_regwrite), .out_regdst(b_regdst),
    .out_memread(b_memread), .out_memwrite(b_memwrite), .out_memhalf(b_memhalf),
    .out_branch(b_branch), .out_jump(b_jump), .out_syscall(b_syscall),
    .out_illegal(b_illegal), .out_halted(b_halted), .out_instr_cnt(b_cnt)
  );

  assign a_obs = {a_alumode, a_alusrc, a_signext, a_regwrite, a_regdst, a_memread,
                  a_memwrite, a_memhalf, a_branch, a_jump, a_syscall, a_illegal};

  int n_cmp = 0;
  int n_err = 0;
  logic [18:0] sb_q[$];
  int model_cnt = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference decode: {alumode, alusrc, signext, regwrite, regdst, memread, memwrite, memhalf, branch, jump, syscall, illegal}
  function automatic logic [18:0] exp_ctrl(input logic [31:0] ins);
    logic [3:0] am;
    logic [1:0] as, rd, br, jp;
    logic       se, rw, mr, mw, mh, sc, il;
    am = 0; as = 0; rd = 0; br = 0; jp = 0;
    se = 0; rw = 0; mr = 0; mw = 0; mh = 0; sc = 0; il = 0;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20, 6'h21: begin am = 5;  rw = 1; end
        6'h22:        begin am = 6;  rw = 1; end
        6'h24:        begin am = 7;  rw = 1; end
        6'h25:        begin am = 8;  rw = 1; end
        6'h26:        begin am = 9;  rw = 1; end
        6'h27:        begin am = 10; rw = 1; end
        6'h2A:        begin am = 11; rw = 1; end
        6'h2B:        begin am = 12; rw = 1; end
        6'h00:        begin am = 0;  as = 2; rw = 1; end
        6'h02:        begin am = 2;  as = 2; rw = 1; end
        6'h03:        begin am = 1;  as = 2; rw = 1; end
        6'h06:        begin am = 2;  as = 3; rw = 1; end
        6'h08:        jp = 2;
        6'h0C:        sc = 1;
        default:      il = 1;
      endcase
      6'h08, 6'h09: begin am = 5;  as = 1; se = 1; rw = 1; rd = 1; end
      6'h0C:        begin am = 7;  as = 1; rw = 1; rd = 1; end
      6'h0D:        begin am = 8;  as = 1; rw = 1; rd = 1; end
      6'h0A:        begin am = 11; as = 1; se = 1; rw = 1; rd = 1; end
      6'h23:        begin am = 5;  as = 1; se = 1; mr = 1; rw = 1; rd = 1; end
      6'h25:        begin am = 5;  as = 1; se = 1; mr = 1; rw = 1; rd = 1; mh = 1; end
      6'h2B:        begin am = 5;  as = 1; se = 1; mw = 1; end
      6'h04:        begin am = 6;  br = 1; end
      6'h05:        begin am = 6;  br = 2; end
      6'h01:        if (ins[20:16] == 5'd1) begin am = 11; br = 3; end else il = 1;
      6'h02:        jp = 1;
      6'h03:        begin jp = 1; rw = 1; rd = 2; end
      default:      il = 1;
    endcase
    return {am, as, se, rw, rd, mr, mw, mh, br, jp, sc, il};
  endfunction

  // scoreboard: push on accept, pop on hand-off, drop on flush
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      model_cnt = 0;
    end else if (a_flush) begin
      if (a_ovld && sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      if (a_ovld && a_dsready) begin
        if (sb_q.size() == 0) chk_eq("sb_underflow", 1, 0);
        else chk_eq("sb_ctrl", a_obs, sb_q.pop_front());
        model_cnt++;
      end
      if (a_valid && a_rdy) sb_q.push_back(exp_ctrl(a_instr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam int NTBL = 30;
  logic [31:0] tbl [NTBL] = '{
    32'h00221820, 32'h3423000F, 32'h8C220004, 32'hAC220004, 32'h10220003,
    32'h14220003, 32'h04210003, 32'h08000010, 32'h0C000010, 32'h03E00008,
    32'h00021080, 32'h00021083, 32'h00021082, 32'h00431006, 32'h00221822,
    32'h00221824, 32'h00221825, 32'h00221826, 32'h00221827, 32'h0022182A,
    32'h0022182B, 32'h20220005, 32'h24220005, 32'h3022FFFF, 32'h2822FFFF,
    32'h94220002, 32'h0000000C, 32'hFC000000, 32'h0000003F, 32'h04020001
  };

  int b_exp [4] = '{2, 3, 3, 3};

  initial begin
    rst = 1; a_valid = 0; a_instr = 0; a_dsready = 0; a_flush = 0; a_resume = 0;
    b_valid = 0; b_instr = 0; b_dsready = 0; b_flush = 0; b_resume = 0;
    #12;
    chk_eq("rst_valid", a_ovld, 0);
    chk_eq("rst_ready", a_rdy, 0);
    chk_eq("rst_cnt", a_cnt, 0);
    chk_eq("rst_halted", a_halted, 0);
    chk_eq("rst_fields", a_obs, 0);
    step();
    rst = 0;

    // back-to-back add, ori
    a_dsready = 1; a_valid = 1; a_instr = 32'h00221820;
    step();
    chk_eq("add_alumode", a_alumode, 5);
    chk_eq("add_regdst", a_regdst, 0);
    a_instr = 32'h3423000F;
    step();
    chk_eq("ori_alumode", a_alumode, 8);
    chk_eq("ori_alusrc", a_alusrc, 1);
    chk_eq("ori_signext", a_signext, 0);
    a_valid = 0;
    step();
    chk_eq("stream_cnt", a_cnt, 2);

    // backpressure holds lw
    a_dsready = 0; a_valid = 1; a_instr = 32'h8C220004;
    step();
    a_valid = 0;
    repeat (3) begin
      chk_eq("bp_valid", a_ovld, 1);
      chk_eq("bp_ready", a_rdy, 0);
      chk_eq("bp_fields", a_obs, exp_ctrl(32'h8C220004));
      step();
    end
    a_dsready = 1;
    step();
    chk_eq("bp_cnt", a_cnt, 3);
    chk_eq("bp_drained", a_ovld, 0);

    // syscall halts after hand-off
    a_dsready = 0; a_valid = 1; a_instr = 32'h0000000C;
    step();
    a_valid = 0;
    chk_eq("sys_pend_ready", a_rdy, 0);
    chk_eq("sys_pre_halt", a_halted, 0);
    a_dsready = 1;
    step();
    chk_eq("sys_halted", a_halted, 1);
    chk_eq("sys_halt_ready", a_rdy, 0);
    chk_eq("sys_cnt", a_cnt, 4);
    a_valid = 1; a_instr = 32'h00221820;
    step();
    chk_eq("halt_blocks", a_ovld, 0);
    a_valid = 0; a_resume = 1;
    step();
    a_resume = 0;
    chk_eq("resume_run", a_halted, 0);
    chk_eq("resume_ready", a_rdy, 1);

    // illegal opcode traps
    a_dsready = 0; a_valid = 1; a_instr = 32'hFC000000;
    step();
    a_valid = 0;
    chk_eq("ill_fields", a_obs, 19'h1);
    chk_eq("ill_pend_ready", a_rdy, 0);
    a_dsready = 1;
    step();
    chk_eq("ill_halted", a_halted, 1);
    chk_eq("ill_cnt", a_cnt, 5);
    a_resume = 1;
    step();
    a_resume = 0;

    // resume in the hand-off cycle of a syscall: no halt
    a_dsready = 0; a_valid = 1; a_instr = 32'h0000000C;
    step();
    a_valid = 0; a_dsready = 1; a_resume = 1;
    step();
    a_resume = 0;
    chk_eq("xfer_resume_nohalt", a_halted, 0);
    chk_eq("xfer_resume_cnt", a_cnt, 6);

    // flush a held syscall while new input is offered
    a_dsready = 0; a_valid = 1; a_instr = 32'h0000000C;
    step();
    a_flush = 1; a_instr = 32'h00221820;
    step();
    a_flush = 0; a_valid = 0;
    chk_eq("flush_valid", a_ovld, 0);
    chk_eq("flush_cnt", a_cnt, 6);
    chk_eq("flush_ready", a_rdy, 1);
    a_dsready = 1;
    step();
    chk_eq("flush_nohalt", a_halted, 0);
    chk_eq("flush_cnt2", a_cnt, 6);

    // random stream through the scoreboard
    for (int i = 0; i < 200; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_instr = tbl[$urandom_range(0, NTBL - 1)];
      a_dsready = ($urandom_range(0, 3) != 0);
      a_resume = a_halted;
      step();
    end
    a_valid = 0; a_dsready = 1;
    repeat (4) begin
      a_resume = a_halted;
      step();
    end
    a_resume = 0;
    step();
    chk_eq("rand_cnt", a_cnt, model_cnt);
    chk_eq("rand_sb_empty", sb_q.size(), 0);
    chk_eq("rand_drained", a_ovld, 0);

    // narrow counter saturates; illegal passes without trap
    b_dsready = 1; b_valid = 1; b_instr = 32'hFC000000;
    step();
    b_valid = 0;
    chk_eq("b_ill_flag", b_illegal, 1);
    chk_eq("b_ill_ready", b_rdy, 1);
    step();
    chk_eq("b_ill_nohalt", b_halted, 0);
    chk_eq("b_cnt_1", b_cnt, 1);
    for (int k = 0; k < 4; k++) begin
      b_valid = 1; b_instr = 32'h00221820;
      step();
      b_valid = 0;
      step();
      chk_eq("b_cnt_sat", b_cnt, b_exp[k]);
    end

    // asynchronous reset mid-stream
    a_dsready = 0; a_valid = 1; a_instr = 32'h8C220004;
    step();
    a_valid = 0;
    chk_eq("pre_rst_valid", a_ovld, 1);
    #2;
    rst = 1;
    #1;
    chk_eq("arst_valid", a_ovld, 0);
    chk_eq("arst_fields", a_obs, 0);
    chk_eq("arst_cnt", a_cnt, 0);
    chk_eq("arst_ready", a_rdy, 0);
    chk_eq("arst_b_cnt", b_cnt, 0);
    step();
    rst = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
